rv64g_wb_arbiter: RTL and testbench
===================================

# rv64g_wb_arbiter

Writeback arbiter that shares the register file's single unlock-write port among `NUM_REQ` execution-unit writeback requesters. It uses round-robin arbitration with a valid/ready handshake per requester, and drives the winning write through a one-cycle registered stage onto the regfile's `wr_unlock_*` inputs. The registered stage is also exported as a forwarding port, so issue logic sees a value during the cycle before it is committed to the regfile.

## Interface
- `NUM_REQ`, default 4: number of writeback requesters; must be ≥2.
- `NR`, default `rv64g_pkg::NUM_REGS`: number of architectural registers.
- `DW`, default `rv64g_pkg::XLEN`: data width.
- `AW`, default `$clog2(NR)`: register address width.
- `clk_i`  in  1  clock.
- `arst_ni`  in  1  asynchronous reset, active-low.
- `flush_i`  in  1  suppresses all grants this cycle; does not cancel the output stage.
- `req_valid_i`  in  `NUM_REQ`  requester i has a writeback pending.
- `req_addr_i`  in  `NUM_REQ`×`AW`  destination register of requester i.
- `req_data_i`  in  `NUM_REQ`×`DW`  writeback data of requester i.
- `req_ready_o`  out  `NUM_REQ`  one-hot or zero; requester i is granted this cycle.
- `wr_unlock_en_o`  out  1  regfile write/unlock enable (registered).
- `wr_unlock_addr_o`  out  `AW`  regfile write address (registered).
- `wr_unlock_data_o`  out  `DW`  regfile write data (registered).
- `fwd_valid_o`  out  1  forwarding entry valid; equals `wr_unlock_en_o`.
- `fwd_addr_o`  out  `AW`  forwarding address; equals `wr_unlock_addr_o`.
- `fwd_data_o`  out  `DW`  forwarding data; equals `wr_unlock_data_o`.

## Operation
- **Round-robin pointer:** `rr_ptr_q`, `$clog2(NUM_REQ)` bits, reset 0.
- **Grant search:**
  - Each cycle, search indices `rr_ptr_q`, `rr_ptr_q+1`, … modulo `NUM_REQ` for the first i with `req_valid_i[i]=1`.
  - The winner g gets `req_ready_o[g]=1`; all other ready bits are 0.
  - No valid request, `flush_i=1`, or `arst_ni=0` → `req_ready_o='0`.
- **Transfer:** occurs when `req_valid_i[g] & req_ready_o[g]`.
  - On transfer: `rr_ptr_q <= (g+1) mod NUM_REQ`.
  - With no transfer, `rr_ptr_q` holds.
- **Output stage on transfer:**
  - `wr_unlock_en_o <= (req_addr_i[g] != 0)`.
  - `wr_unlock_addr_o <= req_addr_i[g]`.
  - `wr_unlock_data_o <= req_data_i[g]`.
- **Output stage without transfer:** `wr_unlock_en_o <= 0`; addr and data hold their previous values.
- **Writes to x0:** the request is accepted and consumes the grant, and the pointer advances, but no write is issued.
- **Same destination from several requesters:** only one is granted per cycle; the others wait, and writes commit in grant order.
- **Requester rules:**
  - `req_valid_i` must not depend combinationally on `req_ready_o`.
  - Once raised, `req_valid_i`, `req_addr_i` and `req_data_i` hold stable until transfer.
  - The arbiter does not check these rules; violations give undefined results.
- **`flush_i`:** blocks new grants only. A write already in the output stage still commits on the next edge.
- **Regfile port:** the regfile accepts every write, so there is no back-pressure from the write port.

## Timing
- **Reset (asynchronous):**
  - `rr_ptr_q=0`.
  - `wr_unlock_en_o=0`, `wr_unlock_addr_o=0`, `wr_unlock_data_o=0`.
  - `fwd_*` outputs are 0.
  - `req_ready_o=0`, combinationally while `arst_ni=0`.
- **Grant path:** `req_ready_o` is combinational from `req_valid_i`, `rr_ptr_q`, `flush_i` and `arst_ni`, with zero-cycle grant latency.
- **Latency:** a transfer at edge N sets `wr_unlock_en_o=1` during cycle N→N+1. The regfile commits at edge N+1, so request to architectural visibility is 2 edges.
- **Throughput:** one write per cycle sustained. A single requester held valid is granted every cycle.
- **Fairness:** with all requesters continuously valid, each is granted exactly once every `NUM_REQ` cycles. Maximum wait for a valid request is `NUM_REQ-1` cycles, excluding flush cycles.
- **Reset mid-operation:** the output stage clears immediately and an in-flight write is lost. Requesters must re-present after reset.
- **Pointer wrap:** a grant to `NUM_REQ-1` sets `rr_ptr_q=0`.

## Test plan
- **Reset values:** `arst_ni=0` with all `req_valid_i=1` → `req_ready_o=0`, `wr_unlock_en_o=0`, all outputs 0. After release, the first grant goes to requester 0.
- **Single write:** requester 2 only, addr=5, data=0xDEAD_BEEF → `req_ready_o=4'b0100` in the same cycle. Next cycle `wr_unlock_en_o=1`, addr=5, data=0xDEAD_BEEF, `fwd_*` identical. The following cycle `wr_unlock_en_o=0`.
- **Round-robin fairness:** all four valid for 8 cycles with distinct addrs 1–4 → grant order 0,1,2,3,0,1,2,3, and `wr_unlock_en_o=1` on every cycle from cycle 1 on.
- **Wrap and skip:** `rr_ptr_q=3`, only requesters 1 and 3 valid → 3 is granted, then 1. The pointer goes 3→0→2.
- **x0 and collision:** requester 0 with addr=0 and requester 1 with addr=7, both valid → requester 0 is granted and produces no write (`wr_unlock_en_o=0`). Next cycle requester 1 is granted and addr 7 is written.
- **Flush and mid-reset:**
  - `flush_i=1` for 2 cycles while valid → `req_ready_o=0`, no pointer change. A write already in the stage still appears.
  - Asserting `arst_ni=0` while `wr_unlock_en_o=1` → `wr_unlock_en_o` drops to 0 immediately.

Source files
------------

// File: rtl/rv64g_wb_arbiter.sv
// rtl/rv64g_wb_arbiter.sv - round-robin writeback arbiter feeding the regfile unlock-write port

package rv64g_pkg;
  localparam int XLEN     = 64;
  localparam int NUM_REGS = 32;
endpackage

module rv64g_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NR      = rv64g_pkg::NUM_REGS,
  parameter int DW      = rv64g_pkg::XLEN,
  parameter int AW      = $clog2(NR)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  flush_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*AW-1:0] req_addr_i,
  input  logic [NUM_REQ*DW-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  wr_unlock_en_o,
  output logic [AW-1:0]         wr_unlock_addr_o,
  output logic [DW-1:0]         wr_unlock_data_o,
  output logic                  fwd_valid_o,
  output logic [AW-1:0]         fwd_addr_o,
  output logic [DW-1:0]         fwd_data_o
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] gnt_idx;
  logic          gnt_found;
  logic          transfer;
  int            gnt_sel;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;

  // Search from the round-robin pointer for the first valid requester; the
  // grant is gated by flush and by reset so nothing is accepted during either.
  always_comb begin
    gnt_found   = 1'b0;
    gnt_idx     = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
    if (gnt_found && !flush_i && arst_ni) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  // Ready is only raised for a valid requester, so any ready bit is a transfer.
  assign transfer = |req_ready_o;
  assign gnt_sel  = int'(gnt_idx);
  assign gnt_addr = req_addr_i[gnt_sel*AW +: AW];
  assign gnt_data = req_data_i[gnt_sel*DW +: DW];

  // Pointer moves to the slot after the winner, wrapping at NUM_REQ-1.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rr_ptr_q <= '0;
    end else if (transfer) begin
      if (gnt_idx == PW'(NUM_REQ - 1)) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= gnt_idx + 1'b1;
      end
    end
  end

  // Output stage: x0 writes consume the grant but never raise the enable;
  // without a transfer only the enable drops, addr/data keep their last value.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_unlock_en_o   <= 1'b0;
      wr_unlock_addr_o <= '0;
      wr_unlock_data_o <= '0;
    end else if (transfer) begin
      wr_unlock_en_o   <= (gnt_addr != '0);
      wr_unlock_addr_o <= gnt_addr;
      wr_unlock_data_o <= gnt_data;
    end else begin
      wr_unlock_en_o   <= 1'b0;
    end
  end

  // Forwarding view is the same registered stage, visible a cycle before commit.
  assign fwd_valid_o = wr_unlock_en_o;
  assign fwd_addr_o  = wr_unlock_addr_o;
  assign fwd_data_o  = wr_unlock_data_o;

endmodule

// File: tb/tb_rv64g_wb_arbiter.sv
// tb/tb_rv64g_wb_arbiter.sv - directed table-driven bench for rv64g_wb_arbiter

module tb_rv64g_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 64;

  localparam logic [DW-1:0] D0 = 64'h1000_0000_0000_0001;
  localparam logic [DW-1:0] D1 = 64'h2222_0000_0000_2111;
  localparam logic [DW-1:0] D2 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [DW-1:0] D3 = 64'h3333_3333_3333_3333;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            fwd_valid;
  logic [AW-1:0]   fwd_addr;
  logic [DW-1:0]   fwd_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv64g_wb_arbiter #(.NUM_REQ(N), .NR(32), .DW(DW), .AW(AW)) dut (
    .clk_i            (clk),
    .arst_ni          (arst_n),
    .flush_i          (flush),
    .req_valid_i      (req_valid),
    .req_addr_i       (req_addr),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .wr_unlock_en_o   (wr_en),
    .wr_unlock_addr_o (wr_addr),
    .wr_unlock_data_o (wr_data),
    .fwd_valid_o      (fwd_valid),
    .fwd_addr_o       (fwd_addr),
    .fwd_data_o       (fwd_data)
  );

  typedef struct packed {
    logic            flush;
    logic [N-1:0]    valid;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    exp_ready;
    logic            exp_en;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                     input logic [N-1:0] r, input logic e, input logic [AW-1:0] ea,
                     input logic [DW-1:0] ed);
    vec_t t;
    t.flush = f; t.valid = v; t.addr = a;
    t.exp_ready = r; t.exp_en = e; t.exp_addr = ea; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] r, input logic e,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, ".ready"}, DW'(req_ready), DW'(r));
    chk({tag, ".en"}, DW'(wr_en), DW'(e));
    chk({tag, ".addr"}, DW'(wr_addr), DW'(a));
    chk({tag, ".data"}, wr_data, d);
    chk({tag, ".fwd_valid"}, DW'(fwd_valid), DW'(e));
    chk({tag, ".fwd_addr"}, DW'(fwd_addr), DW'(a));
    chk({tag, ".fwd_data"}, fwd_data, d);
  endtask

  initial begin
    // Outputs listed per row are what is visible during that cycle (result of the previous row's transfer).
    //   flush valid    addrs {a3,a2,a1,a0}          ready    en addr  data
    add(0, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 4'b0100, 0, 5'd0, 64'h0);   // single write, ptr->3
    add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1, 5'd5, D2);
    add(0, 4'b1010, {5'd4, 5'd0, 5'd2, 5'd0}, 4'b1000, 0, 5'd5, D2);      // ptr=3: 3 wins, ptr->0
    add(0, 4'b0010, {5'd0, 5'd0, 5'd2, 5'd0}, 4'b0010, 1, 5'd4, D3);      // skip 0, 1 wins, ptr->2
    add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1, 5'd2, D1);
    add(0, 4'b1000, {5'd4, 5'd0, 5'd0, 5'd0}, 4'b1000, 0, 5'd2, D1);      // ptr 2 -> 0
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0001, 1, 5'd4, D3);      // fairness
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0010, 1, 5'd1, D0);
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0100, 1, 5'd2, D1);
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1000, 1, 5'd3, D2);
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0001, 1, 5'd4, D3);
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0010, 1, 5'd1, D0);
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0100, 1, 5'd2, D1);
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1000, 1, 5'd3, D2);
    add(1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 1, 5'd4, D3);      // flush, staged write still out
    add(1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 0, 5'd4, D3);
    add(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0001, 0, 5'd4, D3);      // ptr unchanged by flush
    add(0, 4'b1000, {5'd4, 5'd0, 5'd0, 5'd0}, 4'b1000, 1, 5'd1, D0);      // ptr 1 -> 0
    add(0, 4'b0011, {5'd0, 5'd0, 5'd7, 5'd0}, 4'b0001, 1, 5'd4, D3);      // x0 request wins
    add(0, 4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 4'b0010, 0, 5'd0, D0);      // x0: no enable
    add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1, 5'd7, D1);
    add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 0, 5'd7, D1);      // ptr now 2

    req_data  = {D3, D2, D1, D0};
    flush     = 1'b0;
    req_valid = 4'b1111;
    req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    arst_n    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_out("reset", 4'b0000, 1'b0, 5'd0, 64'h0);
    req_valid = 4'b0000;
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      flush     = vecs[i].flush;
      req_valid = vecs[i].valid;
      req_addr  = vecs[i].addr;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_en,
              vecs[i].exp_addr, vecs[i].exp_data);
    end

    // Mid-operation reset: ptr=2, requester 0 wins after wrap, then reset kills the staged write.
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 4'b0001;
    req_addr  = {5'd0, 5'd0, 5'd0, 5'd9};
    #1;
    chk("midrst.ready", DW'(req_ready), DW'(4'b0001));
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    #1;
    chk("midrst.en_before", DW'(wr_en), 64'h1);
    chk("midrst.addr_before", DW'(wr_addr), 64'd9);
    arst_n = 1'b0;
    #1;
    chk_out("midrst", 4'b0000, 1'b0, 5'd0, 64'h0);
    req_valid = 4'b1111;
    #1;
    chk("inrst.ready", DW'(req_ready), 64'h0);
    @(negedge clk);
    arst_n    = 1'b1;
    req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    chk("postrst.ready", DW'(req_ready), DW'(4'b0001));
    @(negedge clk);
    #1;
    chk("postrst.next", DW'(req_ready), DW'(4'b0010));
    chk("postrst.en", DW'(wr_en), 64'h1);
    chk("postrst.addr", DW'(wr_addr), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
